inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the DCE12MIPS pipeline. It owns the program counter, drives the combinational instruction ROM (`rom_addr` out; `rom_data`/`rom_accessable` in), and registers each fetched word into a single-entry IF/ID output register with a valid/ready handshake to decode. It also accepts PC redirects from branch, jump and exception logic, and parks in a FAULT state when the ROM reports an address as not accessible.

## Interface
- `RESET_PC`, 32'h00000000, PC value loaded on reset (boot stub).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  32  fetch address, combinationally equal to the PC register.
- `rom_data`  in  32  instruction word from ROM for `rom_addr`, same cycle.
- `rom_accessable`  in  1  ROM hit flag for `rom_addr`, same cycle.
- `redirect_valid`  in  1  load `redirect_pc` and flush the stage.
- `redirect_pc`  in  32  new fetch address.
- `id_ready`  in  1  decode accepts `id_*` this cycle.
- `id_valid`  out  1  `id_*` holds a valid instruction.
- `id_inst`  out  32  fetched instruction.
- `id_pc`  out  32  address of `id_inst`.
- `id_pc_plus4`  out  32  `id_pc + 4`, modulo 2^32.
- `fault`  out  1  high while in FAULT.
- `fault_pc`  out  32  PC that returned not accessible.
- `fetch_count`  out  32  number of instructions accepted by decode, wraps.

## Operation
- Reset values: PC = `RESET_PC`; state = RUN; `id_valid` = 0; `id_inst`, `id_pc`, `id_pc_plus4`, `fault_pc`, `fetch_count` = 0; `fault` = 0.
- `load_ok = !id_valid || id_ready` means the output register is free, or is being freed, this cycle.
- States are RUN and FAULT. `fault = (state == FAULT)`.
- Each clock edge applies exactly one of the following, in priority order:
  1. `redirect_valid`: PC <= `redirect_pc`, `id_valid` <= 0 (the held instruction is discarded), state <= RUN. This applies in either state.
  2. RUN, `load_ok`, `rom_accessable`: `id_inst` <= `rom_data`, `id_pc` <= PC, `id_pc_plus4` <= PC+4, `id_valid` <= 1, PC <= PC+4.
  3. RUN, `load_ok`, `!rom_accessable`: state <= FAULT, `fault_pc` <= PC, `id_valid` <= 0, PC unchanged.
  4. RUN, `!load_ok`: all registers hold. A not-accessible PC is not flagged until `load_ok`.
  5. FAULT: PC holds; `id_valid` <= 0. Only a redirect or reset leaves FAULT.
- Misaligned PC (`[1:0] != 0`) is not checked here. The ROM reports it as not accessible, so it leads to FAULT.
- PC+4 at 32'hFFFFFFFC wraps to 0. There is no fault for the wrap itself.
- `fetch_count` increments on every edge where `id_valid && id_ready && !redirect_valid`. A flushed instruction is not counted. The counter wraps at 2^32.
- `fault_pc` holds its value after leaving FAULT, until the next fault.

## Timing
- The ROM path is combinational, so fetch latency is 1 cycle: PC = A during cycle N gives `id_valid` = 1 with `id_pc` = A in cycle N+1.
- Throughput is 1 instruction per cycle while `id_ready` = 1.
- Redirect in cycle N: `id_valid` = 0 in N+1, and the target instruction is on `id_*` in N+2 (exactly one bubble).
- Stall: while `id_valid && !id_ready`, all `id_*` outputs are stable and PC does not advance.
- `fault` rises in the cycle after the failing fetch edge. It falls in the cycle after a redirect edge.
- Asserting `reset` in any cycle, including mid-stall or in FAULT, immediately forces all reset values with no clock needed. The first fetch is at the first rising edge after deassertion.

## Test plan
- Reset release with boot ROM model, `id_ready` = 1:
  - `id_*` show (pc 0x00, 0x3c110040), (0x04, 0x26310000), (0x08, 0x02200008) on consecutive cycles.
  - `fetch_count` reaches 3.
- Hold `id_ready` = 0 for 3 cycles with `id_pc` = 0x04: `id_*` stay frozen and `rom_addr` stays 0x08. On release, 0x08 follows next cycle with no gaps or duplicates.
- Redirect to 0x00400000 while a stall holds 0x08:
  - The held instruction is dropped and `fetch_count` does not increment.
  - `id_valid` = 0 for one cycle, then `id_pc` = 0x00400000.
- Sequential fetch reaching 0x0C (not accessible in the boot region):
  - `fault` = 1 and `fault_pc` = 0x0000000C; `id_valid` stays 0; `rom_addr` stays 0x0C.
  - A redirect to 0x00400000 clears `fault` and resumes fetching.
- Redirect to 0x00400002 gives `fault` = 1 with `fault_pc` = 0x00400002. A redirect asserted in the same cycle as a fault detection wins, and no fault is raised.
- Assert `reset` mid-stall and while in FAULT: outputs go to reset values asynchronously, and fetch restarts at `RESET_PC` after release.

Source files
------------

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bus bundle between the fetch stage, the instruction ROM,
// the redirect sources (branch/jump/exception) and the decode stage.
//   rom_addr        fetch address (fetch -> ROM)
//   rom_data        instruction word for rom_addr, same cycle (ROM -> fetch)
//   rom_accessable  ROM hit flag for rom_addr, same cycle (ROM -> fetch)
//   redirect_valid  load redirect_pc and flush the stage
//   redirect_pc     new fetch address
//   id_ready        decode accepts id_* this cycle
//   id_valid        id_* holds a valid instruction
//   id_inst         fetched instruction
//   id_pc           address of id_inst
//   id_pc_plus4     id_pc + 4, modulo 2^32
// master = fetch stage, slave = its environment.
interface inst_fetch_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_accessable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    modport master (
        output rom_addr,
        input  rom_data,
        input  rom_accessable,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output id_valid,
        output id_inst,
        output id_pc,
        output id_pc_plus4
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output rom_accessable,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  id_valid,
        input  id_inst,
        input  id_pc,
        input  id_pc_plus4
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage. Owns the PC, reads the combinational
// instruction ROM and registers each word into a single-entry IF/ID register
// with a valid/ready handshake to decode. Parks in FAULT when the ROM reports
// the PC as not accessible; only a redirect or reset leaves FAULT.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   bus          inst_fetch_if.master (ROM, redirect and IF/ID handshake)
//   fault        high while in FAULT
//   fault_pc     PC that returned not accessible (held until next fault)
//   fetch_count  number of instructions accepted by decode, wraps
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | fetching; one word per cycle whenever the IF/ID register is free
// FAULT | ROM refused the PC; PC frozen, id_valid low, waiting for redirect
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    inst_fetch_if.master       bus,
    output logic               fault,
    output logic [31:0]        fault_pc,
    output logic [31:0]        fetch_count
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        load_ok;

    assign bus.rom_addr = pc;

    // The output register is free, or is being emptied by decode this cycle.
    assign load_ok = !bus.id_valid || bus.id_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= RUN;
            pc              <= RESET_PC;
            bus.id_valid    <= 1'b0;
            bus.id_inst     <= 32'h0;
            bus.id_pc       <= 32'h0;
            bus.id_pc_plus4 <= 32'h0;
            fault           <= 1'b0;
            fault_pc        <= 32'h0;
            fetch_count     <= 32'h0;
        end else begin
            // A flushed instruction never counts as delivered.
            if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end

            if (bus.redirect_valid) begin
                pc           <= bus.redirect_pc;
                bus.id_valid <= 1'b0;
                state        <= RUN;
                fault        <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (load_ok) begin
                            if (bus.rom_accessable) begin
                                bus.id_inst     <= bus.rom_data;
                                bus.id_pc       <= pc;
                                bus.id_pc_plus4 <= pc + 32'd4;
                                bus.id_valid    <= 1'b1;
                                pc              <= pc + 32'd4;
                            end else begin
                                state        <= FAULT;
                                fault        <= 1'b1;
                                fault_pc     <= pc;
                                bus.id_valid <= 1'b0;
                            end
                        end
                        // !load_ok: decode is stalling, everything holds; a bad
                        // PC is only reported once it would actually be loaded.
                    end
                    FAULT: begin
                        bus.id_valid <= 1'b0;
                    end
                    default: begin
                        state        <= RUN;
                        fault        <= 1'b0;
                        bus.id_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic clk;
    logic reset;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int n_tests;
    int n_fail;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .fault       (fault),
        .fault_pc    (fault_pc),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: boot stub at 0x00..0x08, a code page at 0x00400000, and the
    // top two words of the address space (for the PC wrap case).
    function automatic logic rom_hit(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 1'b0;
        if (a == 32'h0 || a == 32'h4 || a == 32'h8) return 1'b1;
        if (a >= 32'h0040_0000 && a < 32'h0040_0100) return 1'b1;
        if (a == 32'hFFFF_FFF8 || a == 32'hFFFF_FFFC) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (!rom_hit(a))       return 32'hDEAD_BEEF;
        if (a == 32'h0)        return 32'h3c11_0040;
        if (a == 32'h4)        return 32'h2631_0000;
        if (a == 32'h8)        return 32'h0220_0008;
        if (a == 32'hFFFF_FFF8) return 32'hAC00_0001;
        if (a == 32'hFFFF_FFFC) return 32'hAC00_0002;
        return a ^ 32'h8C00_0000;
    endfunction

    assign bus.rom_data       = rom_word(bus.rom_addr);
    assign bus.rom_accessable = rom_hit(bus.rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs driven after the check of a cycle take effect at the next edge.
    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_fault;
        logic [31:0] e_fpc;
        logic [31:0] e_addr;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } acc_t;

    vec_t vecs[25];
    acc_t sb[$];

    task automatic check_reset_values(input string tag);
        chk({tag, ".valid"},   {31'h0, bus.id_valid}, 32'h0);
        chk({tag, ".inst"},    bus.id_inst, 32'h0);
        chk({tag, ".pc"},      bus.id_pc, 32'h0);
        chk({tag, ".pc4"},     bus.id_pc_plus4, 32'h0);
        chk({tag, ".fault"},   {31'h0, fault}, 32'h0);
        chk({tag, ".fpc"},     fault_pc, 32'h0);
        chk({tag, ".cnt"},     fetch_count, 32'h0);
        chk({tag, ".addr"},    bus.rom_addr, 32'h0);
    endtask

    initial begin
        acc_t e;
        acc_t got;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;

        //             rdy rv  rpc            valid pc             flt fpc            addr           cnt
        vecs[0]  = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0,          0};
        vecs[1]  = '{1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h4,          0};
        vecs[2]  = '{0, 0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h8,          1};
        vecs[3]  = '{0, 0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h8,          1};
        vecs[4]  = '{0, 0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h8,          1};
        vecs[5]  = '{1, 0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h8,          1};
        vecs[6]  = '{0, 0, 32'h0,          1, 32'h8,          0, 32'h0,          32'hC,          2};
        vecs[7]  = '{1, 1, 32'h0040_0000,  1, 32'h8,          0, 32'h0,          32'hC,          2};
        vecs[8]  = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0040_0000,  2};
        vecs[9]  = '{1, 1, 32'h8,          1, 32'h0040_0000,  0, 32'h0,          32'h0040_0004,  2};
        vecs[10] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h8,          2};
        vecs[11] = '{1, 0, 32'h0,          1, 32'h8,          0, 32'h0,          32'hC,          2};
        vecs[12] = '{1, 0, 32'h0,          0, 32'h0,          1, 32'hC,          32'hC,          3};
        vecs[13] = '{1, 1, 32'h0040_0000,  0, 32'h0,          1, 32'hC,          32'hC,          3};
        vecs[14] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'hC,          32'h0040_0000,  3};
        vecs[15] = '{1, 1, 32'h0040_0002,  1, 32'h0040_0000,  0, 32'hC,          32'h0040_0004,  3};
        vecs[16] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'hC,          32'h0040_0002,  3};
        vecs[17] = '{1, 1, 32'h0040_0004,  0, 32'h0,          1, 32'h0040_0002,  32'h0040_0002,  3};
        vecs[18] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0040_0002,  32'h0040_0004,  3};
        vecs[19] = '{1, 1, 32'hC,          1, 32'h0040_0004,  0, 32'h0040_0002,  32'h0040_0008,  3};
        vecs[20] = '{1, 1, 32'hFFFF_FFF8,  0, 32'h0,          0, 32'h0040_0002,  32'hC,          3};
        vecs[21] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0040_0002,  32'hFFFF_FFF8,  3};
        vecs[22] = '{1, 0, 32'h0,          1, 32'hFFFF_FFF8,  0, 32'h0040_0002,  32'hFFFF_FFFC,  3};
        vecs[23] = '{1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0040_0002,  32'h0,          4};
        vecs[24] = '{0, 0, 32'h0,          1, 32'h0,          0, 32'h0040_0002,  32'h4,          5};

        // Instructions decode is expected to accept, in order.
        sb.push_back('{32'h0000_0000, 32'h3c11_0040});
        sb.push_back('{32'h0000_0004, 32'h2631_0000});
        sb.push_back('{32'h0000_0008, 32'h0220_0008});
        sb.push_back('{32'hFFFF_FFF8, 32'hAC00_0001});
        sb.push_back('{32'hFFFF_FFFC, 32'hAC00_0002});

        repeat (3) @(negedge clk);
        check_reset_values("rst0");
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            chk($sformatf("v%0d.valid", i), {31'h0, bus.id_valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d.addr", i),  bus.rom_addr, vecs[i].e_addr);
            chk($sformatf("v%0d.fault", i), {31'h0, fault}, {31'h0, vecs[i].e_fault});
            chk($sformatf("v%0d.fpc", i),   fault_pc, vecs[i].e_fpc);
            chk($sformatf("v%0d.cnt", i),   fetch_count, vecs[i].e_cnt);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d.pc", i),   bus.id_pc, vecs[i].e_pc);
                chk($sformatf("v%0d.pc4", i),  bus.id_pc_plus4, vecs[i].e_pc + 32'd4);
                chk($sformatf("v%0d.inst", i), bus.id_inst, rom_word(vecs[i].e_pc));
            end
            bus.id_ready       = vecs[i].ready;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc    = vecs[i].rpc;
            #1;
            if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
                if (sb.size() == 0) begin
                    chk($sformatf("sb%0d.unexpected", i), bus.id_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    got.pc   = bus.id_pc;
                    got.inst = bus.id_inst;
                    chk($sformatf("sb%0d.pc", i),   got.pc, e.pc);
                    chk($sformatf("sb%0d.inst", i), got.inst, e.inst);
                end
            end
            @(negedge clk);
        end
        chk("sb.left", sb.size(), 32'h0);

        // Reset mid-stall: pc 0x00 held with id_ready low.
        @(negedge clk);
        chk("stall.valid", {31'h0, bus.id_valid}, 32'h1);
        #2 reset = 1'b0;
        #1 check_reset_values("rst_stall");
        @(negedge clk);
        reset = 1'b1;
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("restart1.valid", {31'h0, bus.id_valid}, 32'h1);
        chk("restart1.pc",    bus.id_pc, 32'h0);
        chk("restart1.inst",  bus.id_inst, 32'h3c11_0040);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("f2.fault", {31'h0, fault}, 32'h1);
        chk("f2.fpc",   fault_pc, 32'hC);
        chk("f2.cnt",   fetch_count, 32'h0);
        // Reset while in FAULT.
        #2 reset = 1'b0;
        #1 check_reset_values("rst_fault");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("restart2.valid", {31'h0, bus.id_valid}, 32'h1);
        chk("restart2.pc",    bus.id_pc, 32'h0);
        chk("restart2.addr",  bus.rom_addr, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
